rr_arbiter_8: RTL
=================

# rr_arbiter_8

Eight-requester round-robin arbiter that shares one downstream resource among eight request lines. Produces a registered one-hot grant plus its 3-bit binary index, so the granted requester's number can drive a mux select or a downstream encoder/decoder directly. Grants are held while the owner keeps requesting, bounded by a programmable hold limit to guarantee fairness. It sits between the requesting blocks and the shared datapath as the single point of ownership decision.

## Interface
- MAX_HOLD, 4, max consecutive cycles one owner keeps the grant while others are pending; 0 = unlimited (owner keeps until it releases); legal 0..255
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
- req  input  8  request lines, req[i] high = requester i wants the resource; level-sensitive
- gnt  output  8  registered one-hot grant; all-zero when no owner
- gnt_idx  output  3  binary index of current owner (gnt[gnt_idx]==1 when gnt_valid)
- gnt_valid  output  1  high when exactly one bit of gnt is set

## Operation
- States: IDLE (no owner) and OWNED (one owner, index in owner register).
- Internal: last pointer `ptr[2:0]` (index of most recent owner), hold counter `hcnt` (8 bits).
- Search order for a new winner: ptr+1, ptr+2, ..., ptr+7, ptr (mod 8); first index with req high wins. Previous owner therefore has lowest priority.
- IDLE: if any req high, next edge -> OWNED with winner; gnt/gnt_idx/gnt_valid load winner; ptr <= winner; hcnt <= 1. If req==0, stay IDLE.
- OWNED, owner's req low (release): same edge re-arbitrates over current req with owner excluded by search order; if a winner exists, go directly to it (back-to-back, no idle cycle), else -> IDLE with gnt=0, gnt_valid=0, gnt_idx holding last value.
- OWNED, owner's req high, MAX_HOLD!=0, hcnt==MAX_HOLD, and any other req high: forced rotation to next winner in search order; hcnt <= 1.
- OWNED, owner's req high, hcnt==MAX_HOLD, no other req: owner retains; hcnt <= 1 (fresh window).
- OWNED otherwise: owner retains; hcnt <= hcnt+1 (saturates at 255; with MAX_HOLD=0 counter value is irrelevant).
- Index rule: gnt_idx is standard binary, gnt == (8'b1 << gnt_idx) whenever gnt_valid.
- Grant never changes except at the decision points above; requests arriving for non-owners never preempt before release or hold expiry.

## Timing
- Reset (rst high at edge): gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, state IDLE, ptr=3'd7 (first search starts at 0), hcnt=0. rst dominates all other inputs.
- Reset mid-grant: ownership dropped at that edge; gnt=0 the following cycle regardless of req.
- Latency: req rising in cycle N (idle arbiter) -> gnt visible after edge N+1 (1 cycle, registered).
- Release latency: owner drops req in cycle N -> new gnt (or gnt=0) after edge N+1. Owner must not rely on gnt remaining after its req falls.
- All outputs registered; no combinational path req->gnt.
- Fairness bound (MAX_HOLD=M>0): a continuously requesting requester is granted within 7*M+1 cycles.
- Simultaneous release + new requests: resolved in the same edge per search order from ptr.

## Test plan
- Reset: drive req=8'hFF with rst high 3 cycles -> gnt=8'h00, gnt_idx=0, gnt_valid=0 throughout; first edge after rst low -> gnt=8'h01, gnt_idx=0.
- Single requester: req=8'h20 from idle -> after 1 edge gnt=8'h20, gnt_idx=5, held indefinitely with MAX_HOLD=4 (no others); drop req -> next edge gnt=0, gnt_valid=0.
- Rotation: req=8'hFF constant, MAX_HOLD=4 -> owner sequence 0,1,2,...,7,0 each held exactly 4 cycles, no gap cycles.
- Release handoff: owner 3, req=8'h89 (3 drops to give 8'h81 in same cycle) -> next owner 7, then on its release owner 0; no idle cycle between.
- Unlimited hold: MAX_HOLD=0, owner 2 with req=8'h06 held 300 cycles -> gnt stays 8'h04; drop bit 2 -> gnt=8'h02 next edge.
- Reset mid-operation: owner 6 in hold cycle 2, assert rst one cycle with req=8'h41 -> gnt=0 next cycle; after release of rst grant goes to index 0 (ptr reset to 7).

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary index and
// a bounded hold window so a persistent owner cannot starve the other requesters.
module rr_arbiter_8 #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       o_dbg_state
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OWNED = 1'b1;

   localparam logic [7:0] HOLD_LIM = MAX_HOLD[7:0];
   localparam bit         HOLD_EN  = (MAX_HOLD != 0);

   logic [0:0] r_state;
   logic [2:0] r_ptr;
   logic [7:0] r_hcnt;
   logic [7:0] r_gnt;
   logic [2:0] r_gnt_idx;
   logic       r_gnt_valid;

   logic       w_found;
   logic [2:0] w_win;
   logic [2:0] w_idx;
   logic       w_owner_req;
   logic       w_expired;

   // Search ptr+1 .. ptr+7 then ptr itself, so the latest owner ranks last.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_ptr;
      w_idx   = r_ptr;
      for (int k = 1; k <= 8; k++) begin
         w_idx = r_ptr + 3'(k);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_owner_req = req[r_gnt_idx];
   assign w_expired   = HOLD_EN && (r_hcnt == HOLD_LIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= 3'd7;
         r_hcnt      <= 8'd0;
         r_gnt       <= 8'h00;
         r_gnt_idx   <= 3'd0;
         r_gnt_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state     <= ST_OWNED;
                  r_ptr       <= w_win;
                  r_hcnt      <= 8'd1;
                  r_gnt       <= 8'h01 << w_win;
                  r_gnt_idx   <= w_win;
                  r_gnt_valid <= 1'b1;
               end
            end
            default: begin
               if (!w_owner_req) begin
                  if (w_found) begin
                     r_ptr     <= w_win;
                     r_hcnt    <= 8'd1;
                     r_gnt     <= 8'h01 << w_win;
                     r_gnt_idx <= w_win;
                  end else begin
                     r_state     <= ST_IDLE;
                     r_gnt       <= 8'h00;
                     r_gnt_valid <= 1'b0;
                  end
               end else if (w_expired) begin
                  // Owner ranks last in the search, so a different winner means others wait.
                  r_hcnt <= 8'd1;
                  if (w_win != r_gnt_idx) begin
                     r_ptr     <= w_win;
                     r_gnt     <= 8'h01 << w_win;
                     r_gnt_idx <= w_win;
                  end
               end else if (r_hcnt != 8'hFF) begin
                  r_hcnt <= r_hcnt + 8'd1;
               end
            end
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign gnt_idx     = r_gnt_idx;
   assign gnt_valid   = r_gnt_valid;
   assign o_dbg_state = r_state;

endmodule
